// File: rtl/tmcc_sync_if.sv
// rtl/tmcc_sync_if.sv - TMCC synchroniser bit-stream input and frame-field output bundle
// Signals:
//   ce        : clock enable, nothing in the synchroniser updates while low
//   valid_raw : raw carries a demapped TMCC bit this cycle
//   raw       : hard-decision TMCC bit
//   valid_o   : one-cycle pulse, frame fields valid
//   tmcc_info : frame bits B20..B121, B20 is the MSB
//   seg_type  : frame bits B17..B19, B17 is the MSB
//   frame_odd : 1 when the frame sync was w1, 0 when w0
//   locked    : synchroniser is in LOCK
interface tmcc_sync_if;
  logic         ce;
  logic         valid_raw;
  logic         raw;
  logic         valid_o;
  logic [101:0] tmcc_info;
  logic [2:0]   seg_type;
  logic         frame_odd;
  logic         locked;

  modport master (
    output ce, valid_raw, raw,
    input  valid_o, tmcc_info, seg_type, frame_odd, locked
  );

  modport slave (
    input  ce, valid_raw, raw,
    output valid_o, tmcc_info, seg_type, frame_odd, locked
  );
endinterface

// File: rtl/tmcc_sync.sv
// rtl/tmcc_sync.sv - TMCC bit-level frame synchroniser (HUNT/VERIFY/LOCK)
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : tmcc_sync_if.slave; ce/valid_raw/raw in,
//             valid_o/tmcc_info/seg_type/frame_odd/locked out
module tmcc_sync #(
  parameter int LOCK_CNT   = 2,
  parameter int UNLOCK_CNT = 3,
  parameter int MAX_ERR    = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  tmcc_sync_if.slave bus
);

  localparam logic [15:0] W0       = 16'b0011_0101_1110_1110;
  localparam logic [15:0] W1       = ~W0;
  localparam logic [7:0]  POS_SYNC = 8'd16;
  localparam logic [7:0]  POS_LAST = 8'd203;

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCK} state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [15:0]    r_sr;
  logic [7:0]     r_pos;
  logic [2:0]     r_good;
  logic [2:0]     r_miss;
  logic           r_sync_ok;
  logic           r_odd_sh;
  logic [2:0]     r_seg_sh;
  logic [101:0]   r_info_sh;
  logic           r_valid;
  logic [101:0]   r_info;
  logic [2:0]     r_seg;
  logic           r_odd;
  logic           r_locked;

  logic           w_acc;
  logic [15:0]    w_sr_n;
  logic           w_m0;
  logic           w_m1;
  logic           w_match;
  logic [7:0]     w_pos_inc;
  logic [2:0]     w_good_inc;
  logic [2:0]     w_miss_inc;
  logic [7:0]     w_pos_n;
  logic [2:0]     w_good_n;
  logic [2:0]     w_miss_n;
  logic           w_sync_ok_n;
  logic           w_odd_n;
  logic           w_emit;
  logic           w_cap;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  assign w_acc      = bus.ce && bus.valid_raw;
  assign w_sr_n     = {r_sr[14:0], bus.raw};
  assign w_m0       = popcnt16(w_sr_n ^ W0) <= 5'(MAX_ERR);
  assign w_m1       = popcnt16(w_sr_n ^ W1) <= 5'(MAX_ERR);
  assign w_match    = w_m0 || w_m1;
  assign w_pos_inc  = (r_pos == POS_LAST) ? 8'd0 : r_pos + 8'd1;
  assign w_good_inc = r_good + 3'd1;
  assign w_miss_inc = r_miss + 3'd1;
  // Field capture only makes sense once pos tracks a frame.
  assign w_cap      = w_acc && (r_state != ST_HUNT);
  assign w_emit     = w_acc && (r_state == ST_LOCK) && (w_pos_inc == POS_LAST) && r_sync_ok;

  always_comb begin
    w_state_n   = r_state;
    w_pos_n     = r_pos;
    w_good_n    = r_good;
    w_miss_n    = r_miss;
    w_sync_ok_n = r_sync_ok;
    w_odd_n     = r_odd_sh;
    if (w_acc) begin
      case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            w_pos_n  = POS_SYNC;
            w_good_n = 3'd1;
            w_odd_n  = !w_m0;    // w0 wins when both words are within tolerance
            if (LOCK_CNT == 1) begin
              w_state_n   = ST_LOCK;
              w_miss_n    = 3'd0;
              w_sync_ok_n = 1'b1;
            end else begin
              w_state_n = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          w_pos_n = w_pos_inc;
          if (w_pos_inc == POS_SYNC) begin
            if (w_match) begin
              w_good_n = w_good_inc;
              w_odd_n  = !w_m0;
              if (w_good_inc == 3'(LOCK_CNT)) begin
                w_state_n   = ST_LOCK;
                w_miss_n    = 3'd0;
                w_sync_ok_n = 1'b1;
              end
            end else begin
              // The failing window is not re-tested; hunting restarts on the next bit.
              w_state_n   = ST_HUNT;
              w_good_n    = 3'd0;
              w_miss_n    = 3'd0;
              w_sync_ok_n = 1'b0;
            end
          end
        end
        ST_LOCK: begin
          w_pos_n = w_pos_inc;
          if (w_pos_inc == POS_SYNC) begin
            if (w_match) begin
              w_miss_n    = 3'd0;
              w_sync_ok_n = 1'b1;
              w_odd_n     = !w_m0;
            end else begin
              w_miss_n    = w_miss_inc;
              w_sync_ok_n = 1'b0;
              if (w_miss_inc == 3'(UNLOCK_CNT)) begin
                w_state_n = ST_HUNT;
                w_good_n  = 3'd0;
                w_miss_n  = 3'd0;
              end
            end
          end
        end
        default: w_state_n = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr      <= 16'd0;
      r_pos     <= 8'd0;
      r_good    <= 3'd0;
      r_miss    <= 3'd0;
      r_sync_ok <= 1'b0;
      r_odd_sh  <= 1'b0;
      r_seg_sh  <= 3'd0;
      r_info_sh <= 102'd0;
      r_valid   <= 1'b0;
      r_info    <= 102'd0;
      r_seg     <= 3'd0;
      r_odd     <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      if (w_acc) r_sr <= w_sr_n;
      r_pos     <= w_pos_n;
      r_good    <= w_good_n;
      r_miss    <= w_miss_n;
      r_sync_ok <= w_sync_ok_n;
      r_odd_sh  <= w_odd_n;
      if (w_cap && (w_pos_inc >= 8'd17) && (w_pos_inc <= 8'd19))
        r_seg_sh <= {r_seg_sh[1:0], bus.raw};
      if (w_cap && (w_pos_inc >= 8'd20) && (w_pos_inc <= 8'd121))
        r_info_sh <= {r_info_sh[100:0], bus.raw};
      // A pulse raised just before ce drops is held until ce returns.
      if (bus.ce) r_valid <= w_emit;
      if (w_emit) begin
        r_info <= r_info_sh;
        r_seg  <= r_seg_sh;
        r_odd  <= r_odd_sh;
      end
      r_locked <= (w_state_n == ST_LOCK);
    end
  end

  assign bus.valid_o   = r_valid;
  assign bus.tmcc_info = r_info;
  assign bus.seg_type  = r_seg;
  assign bus.frame_odd = r_odd;
  assign bus.locked    = r_locked;

endmodule

// File: tb/tb_tmcc_sync.sv
// tb/tb_tmcc_sync.sv - self-checking bench for tmcc_sync against a frame-level reference model
module tb_tmcc_sync;
  localparam int LOCK_CNT   = 2;
  localparam int UNLOCK_CNT = 3;
  localparam logic [15:0]  W0  = 16'b0011_0101_1110_1110;
  localparam logic [15:0]  W1  = ~W0;
  localparam logic [15:0]  BAD = W0 ^ 16'h000F;
  localparam logic [15:0]  TWO = W0 ^ 16'h0101;
  localparam logic [101:0] ALT = 102'h2AAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam int HUNT = 0, VERIFY = 1, LOCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0, valid_raw = 1'b0, raw = 1'b0;

  int vecs = 0;
  int errs = 0;

  tmcc_sync_if if0 ();
  tmcc_sync_if if1 ();
  assign if0.ce = ce;  assign if0.valid_raw = valid_raw;  assign if0.raw = raw;
  assign if1.ce = ce;  assign if1.valid_raw = valid_raw;  assign if1.raw = raw;

  tmcc_sync #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .MAX_ERR(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  tmcc_sync #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .MAX_ERR(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference model: every accepted bit is kept; frame position is derived
  // arithmetically from the index of the anchoring sync bit, and fields are
  // sliced straight out of the history when a frame completes.
  bit           hist[$];
  int           mode[2], anchor[2], good[2], missc[2];
  bit           sync_ok[2], odd_sh[2];
  logic         e_valid[2], e_odd[2], e_locked[2];
  logic [101:0] e_info[2];
  logic [2:0]   e_seg[2];
  int           pulses[2];
  logic         prev_v[2], last_cev[2];
  logic [101:0] rec_info[$], base_info[$];
  logic [2:0]   rec_seg[$], base_seg[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      mode[m] = HUNT; anchor[m] = 0; good[m] = 0; missc[m] = 0;
      sync_ok[m] = 0; odd_sh[m] = 0;
      e_valid[m] = 0; e_odd[m] = 0; e_locked[m] = 0; e_info[m] = '0; e_seg[m] = '0;
      prev_v[m] = 0; last_cev[m] = 0;
    end
  endtask

  task automatic model_edge(input bit acc, input bit b, input bit c);
    logic [15:0] win;
    int n, d, idx, base;
    bit m0, m1, match, emit;
    if (acc) hist.push_back(b);
    n = hist.size() - 1;
    win = '0;
    for (int k = 0; k < 16; k++) begin
      idx = n - 15 + k;
      if (idx >= 0) win[15-k] = hist[idx];
    end
    for (int m = 0; m < 2; m++) begin
      emit = 0;
      if (acc) begin
        m0 = ($countones(win ^ W0) <= m);
        m1 = ($countones(win ^ W1) <= m);
        match = m0 || m1;
        d = (n - anchor[m]) % 204;
        if (mode[m] == HUNT) begin
          if (match) begin
            anchor[m] = n; good[m] = 1; odd_sh[m] = !m0;
            if (good[m] >= LOCK_CNT) begin
              mode[m] = LOCK; missc[m] = 0; sync_ok[m] = 1;
            end else mode[m] = VERIFY;
          end
        end else if (mode[m] == VERIFY) begin
          if (d == 0) begin
            if (match) begin
              good[m]++; odd_sh[m] = !m0;
              if (good[m] == LOCK_CNT) begin
                mode[m] = LOCK; missc[m] = 0; sync_ok[m] = 1;
              end
            end else begin
              mode[m] = HUNT; good[m] = 0; missc[m] = 0; sync_ok[m] = 0;
            end
          end
        end else begin
          if (d == 0) begin
            if (match) begin
              missc[m] = 0; sync_ok[m] = 1; odd_sh[m] = !m0;
            end else begin
              missc[m]++; sync_ok[m] = 0;
              if (missc[m] == UNLOCK_CNT) begin
                mode[m] = HUNT; good[m] = 0; missc[m] = 0;
              end
            end
          end else if (d == 187 && sync_ok[m]) emit = 1;
        end
        if (emit) begin
          base = n - 203;
          for (int k = 0; k < 3; k++)   e_seg[m][2-k]    = hist[base+17+k];
          for (int k = 0; k < 102; k++) e_info[m][101-k] = hist[base+20+k];
          e_odd[m] = odd_sh[m];
        end
      end
      if (c) e_valid[m] = emit;
      e_locked[m] = (mode[m] == LOCK);
    end
  endtask

  task automatic check_dut(input int m, input logic v, input logic lk, input logic [101:0] inf,
                           input logic [2:0] sg, input logic od, input bit c);
    chk($sformatf("valid_o[%0d]", m), v, e_valid[m]);
    chk($sformatf("locked[%0d]", m), lk, e_locked[m]);
    chk($sformatf("tmcc_info[%0d]", m), inf, e_info[m]);
    chk($sformatf("seg_type[%0d]", m), sg, e_seg[m]);
    chk($sformatf("frame_odd[%0d]", m), od, e_odd[m]);
    if (c) begin
      chk($sformatf("valid_width[%0d]", m), v && last_cev[m], 1'b0);
      last_cev[m] = v;
    end
    if (v && !prev_v[m]) begin
      pulses[m]++;
      if (m == 0) begin rec_info.push_back(inf); rec_seg.push_back(sg); end
    end
    prev_v[m] = v;
  endtask

  task automatic step(input bit c, input bit v, input bit b);
    ce = c; valid_raw = v; raw = b;
    @(posedge clk);
    model_edge(c && v, b, c);
    #1;
    check_dut(0, if0.valid_o, if0.locked, if0.tmcc_info, if0.seg_type, if0.frame_odd, c);
    check_dut(1, if1.valid_o, if1.locked, if1.tmcc_info, if1.seg_type, if1.frame_odd, c);
  endtask

  task automatic send_bit(input bit b, input bit gaps);
    int r;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      r = $urandom_range(0, 2);
      step(r == 1, r == 0, 1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b1, b);
  endtask

  task automatic send_frame(input logic [15:0] sync, input logic [2:0] seg, input logic [101:0] info,
                            input bit gaps, input int first, input int last);
    bit fr[204];
    for (int k = 0; k < 204; k++) fr[k] = 0;
    for (int k = 0; k < 16; k++)  fr[1+k]  = sync[15-k];
    for (int k = 0; k < 3; k++)   fr[17+k] = seg[2-k];
    for (int k = 0; k < 102; k++) fr[20+k] = info[101-k];
    for (int k = first; k <= last; k++) send_bit(fr[k], gaps);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid0"}, if0.valid_o, 1'b0);   chk({tag, "_valid1"}, if1.valid_o, 1'b0);
    chk({tag, "_locked0"}, if0.locked, 1'b0);   chk({tag, "_locked1"}, if1.locked, 1'b0);
    chk({tag, "_info0"}, if0.tmcc_info, 102'd0); chk({tag, "_info1"}, if1.tmcc_info, 102'd0);
    chk({tag, "_seg0"}, if0.seg_type, 3'd0);    chk({tag, "_odd0"}, if0.frame_odd, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    #2; rst_n = 1'b0; #1;
    check_zero(tag);
    ce = 1'b0; valid_raw = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [101:0] rand_info();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[101:0];
  endfunction

  initial begin
    bit pre[57];
    bit seq[74];
    bit ok;
    logic [15:0] w;
    int p0, p1;

    model_reset();
    pulses[0] = 0; pulses[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Clean lock: w0, w1, w0 frames.
    rec_info.delete(); rec_seg.delete();
    p0 = pulses[0];
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    chk("clean_unlocked_f1", if0.locked, 1'b0);
    send_frame(W1, 3'b111, ALT, 0, 0, 15);
    chk("clean_unlocked_pre_b16", if0.locked, 1'b0);
    send_frame(W1, 3'b111, ALT, 0, 16, 16);
    chk("clean_locked_b16", if0.locked, 1'b1);
    send_frame(W1, 3'b111, ALT, 0, 17, 203);
    chk("clean_odd_f2", if0.frame_odd, 1'b1);
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    chk("clean_pulses", pulses[0] - p0, 2);
    chk("clean_info", if0.tmcc_info, ALT);
    chk("clean_seg", if0.seg_type, 3'b111);
    chk("clean_odd_f3", if0.frame_odd, 1'b0);
    base_info = rec_info; base_seg = rec_seg;

    // Misaligned start: random prefix with no sync-like window.
    do_reset("rst_mis");
    do begin
      for (int k = 0; k < 57; k++) pre[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 57; k++) seq[k] = pre[k];
      seq[57] = 0;
      for (int k = 0; k < 16; k++) seq[58+k] = W0[15-k];
      ok = 1;
      for (int e = 0; e < 73; e++) begin
        w = '0;
        for (int k = 0; k < 16; k++) if (e - 15 + k >= 0) w[15-k] = seq[e-15+k];
        if ($countones(w ^ W0) <= 1 || $countones(w ^ W1) <= 1) ok = 0;
      end
    end while (!ok);
    rec_info.delete(); rec_seg.delete();
    p0 = pulses[0];
    for (int k = 0; k < 57; k++) send_bit(pre[k], 0);
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    send_frame(W1, 3'b111, ALT, 0, 0, 203);
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    chk("mis_pulses", pulses[0] - p0, 2);
    chk("mis_count", rec_info.size(), base_info.size());
    for (int k = 0; k < 2; k++) begin
      chk("mis_info", rec_info[k], base_info[k]);
      chk("mis_seg", rec_seg[k], base_seg[k]);
    end

    // Loss of lock after three corrupted syncs.
    do_reset("rst_loss");
    send_frame(W0, 3'b101, rand_info(), 0, 0, 203);
    send_frame(W1, 3'b010, rand_info(), 0, 0, 203);
    chk("loss_locked", if0.locked, 1'b1);
    p0 = pulses[0]; p1 = pulses[1];
    send_frame(BAD, 3'b111, ALT, 0, 0, 203);
    send_frame(BAD, 3'b111, ALT, 0, 0, 203);
    chk("loss_still_locked", if0.locked, 1'b1);
    send_frame(BAD, 3'b111, ALT, 0, 0, 16);
    chk("loss_unlocked0", if0.locked, 1'b0);
    chk("loss_unlocked1", if1.locked, 1'b0);
    send_frame(BAD, 3'b111, ALT, 0, 17, 203);
    chk("loss_no_pulse0", pulses[0] - p0, 0);
    chk("loss_no_pulse1", pulses[1] - p1, 0);

    // One bad sync then good ones: miss counter restarts.
    do_reset("rst_rec");
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    send_frame(W1, 3'b111, ALT, 0, 0, 203);
    p0 = pulses[0];
    send_frame(BAD, 3'b111, ALT, 0, 0, 203);
    chk("rec_locked_bad", if0.locked, 1'b1);
    send_frame(W0, 3'b111, rand_info(), 0, 0, 203);
    send_frame(W1, 3'b111, rand_info(), 0, 0, 203);
    send_frame(BAD, 3'b111, ALT, 0, 0, 203);
    send_frame(BAD, 3'b111, ALT, 0, 0, 203);
    chk("rec_locked_after", if0.locked, 1'b1);
    chk("rec_pulses", pulses[0] - p0, 2);

    // Tolerance: MAX_ERR=1 (dut1) versus MAX_ERR=0 (dut0).
    do_reset("rst_tol");
    send_frame(W0, 3'b011, rand_info(), 0, 0, 203);
    send_frame(W0, 3'b110, rand_info(), 0, 0, 203);
    p0 = pulses[0]; p1 = pulses[1];
    send_frame(W0 ^ (16'd1 << $urandom_range(0, 15)), 3'b001, rand_info(), 0, 0, 203);
    chk("tol_flip1_dut0", pulses[0] - p0, 0);
    chk("tol_flip1_dut1", pulses[1] - p1, 1);
    p0 = pulses[0]; p1 = pulses[1];
    send_frame(TWO, 3'b100, rand_info(), 0, 0, 203);
    chk("tol_flip2_dut0", pulses[0] - p0, 0);
    chk("tol_flip2_dut1", pulses[1] - p1, 0);
    p0 = pulses[0]; p1 = pulses[1];
    send_frame(W1, 3'b010, rand_info(), 0, 0, 203);
    chk("tol_good_dut0", pulses[0] - p0, 1);
    chk("tol_good_dut1", pulses[1] - p1, 1);
    chk("tol_locked0", if0.locked, 1'b1);

    // Flow control: same stream with random valid_raw gaps and ce drops.
    do_reset("rst_flow");
    rec_info.delete(); rec_seg.delete();
    p0 = pulses[0];
    send_frame(W0, 3'b111, ALT, 1, 0, 203);
    send_frame(W1, 3'b111, ALT, 1, 0, 203);
    send_frame(W0, 3'b111, ALT, 1, 0, 203);
    chk("flow_pulses", pulses[0] - p0, 2);
    chk("flow_count", rec_info.size(), base_info.size());
    for (int k = 0; k < 2; k++) begin
      chk("flow_info", rec_info[k], base_info[k]);
      chk("flow_seg", rec_seg[k], base_seg[k]);
    end

    // Reset mid-frame while locked, then re-lock.
    send_frame(W1, 3'b111, ALT, 0, 0, 100);
    chk("mid_locked_before", if0.locked, 1'b1);
    do_reset("rst_mid");
    p0 = pulses[0];
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    chk("mid_unlocked_f1", if0.locked, 1'b0);
    send_frame(W0, 3'b111, ALT, 0, 0, 203);
    chk("mid_relocked", if0.locked, 1'b1);
    chk("mid_pulses", pulses[0] - p0, 1);
    chk("mid_info", if0.tmcc_info, ALT);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tmcc_sync.md
# tmcc_sync

Bit-level TMCC frame synchroniser for the one-seg receiver. It consumes the hard-decision bit stream (`valid_raw`/`raw`) from the BPSK demapper on the TMCC carrier. It hunts for the 16-bit TMCC sync word, tracks 204-bit frame alignment through a HUNT/VERIFY/LOCK state machine, and outputs the 102 TMCC information bits of every verified frame to the downstream TMCC parser/register block.

## Interface
- `LOCK_CNT`, 2: number of consecutive good sync words needed to enter LOCK, counting the one found in HUNT (1..7).
- `UNLOCK_CNT`, 3: number of consecutive bad sync words in LOCK that forces HUNT (1..7).
- `MAX_ERR`, 0: Hamming-distance tolerance for a sync match (0..3).
- `CLK` input 1: system clock.
- `RST` input 1: asynchronous, active-low reset.
- `ce` input 1: clock enable. Nothing updates while low.
- `valid_raw` input 1: `raw` carries a bit this cycle.
- `raw` input 1: TMCC bit from the demapper.
- `valid_o` output 1: one-cycle pulse, frame fields valid.
- `tmcc_info` output 102: frame bits B20..B121; B20 is the MSB.
- `seg_type` output 3: frame bits B17..B19; B17 is the MSB.
- `frame_odd` output 1: 1 if the frame's sync was w1, 0 if w0.
- `locked` output 1: state == LOCK.

## Operation
- A bit is accepted only when `ce && valid_raw`. Every statement below is counted in accepted bits.
- `sr[15:0]` shifts left on each accepted bit; `raw` enters at bit 0.
- Sync words:
  - w0 = 16'b0011_0101_1110_1110
  - w1 = ~w0 = 16'b1100_1010_0001_0001
- `match` = popcount(sr' ^ w0) <= MAX_ERR or popcount(sr' ^ w1) <= MAX_ERR.
  - sr' is the register value including the bit being accepted.
  - If both comparisons pass, w0 wins.
- `pos` (8 bits, 0..203) is the frame index of the last accepted bit. It wraps from 203 to 0.
- States are HUNT, VERIFY and LOCK.
  - **HUNT:** `match` is tested on every accepted bit. On a match: `pos`<=16, `good`<=1, latch `frame_odd`; go to VERIFY, or directly to LOCK if LOCK_CNT==1. No match: stay in HUNT; `pos` is don't-care.
  - **VERIFY:** `pos` increments. `match` is evaluated only at the accepted bit where `pos` becomes 16.
    - Match: `good`+1 and latch `frame_odd`; go to LOCK when `good`+1 == LOCK_CNT.
    - Mismatch: go to HUNT. That same window is not re-tested; hunting resumes from the next bit.
  - **LOCK:** `pos` increments. The check is done at `pos`==16.
    - Match: `miss`<=0, `sync_ok`<=1, latch `frame_odd`.
    - Mismatch: `miss`+1, `sync_ok`<=0. When `miss`+1 == UNLOCK_CNT, go to HUNT.
- Capture: bits at `pos` 17..19 shift into `seg_type`. Bits at `pos` 20..121 shift into the `tmcc_info` shadow register. Parity bits 122..203 are discarded.
- Emit: the accepted bit at `pos`==203 with state LOCK and `sync_ok`==1 does both of the following:
  - copies the shadow registers to the outputs;
  - pulses `valid_o`.
- A frame whose sync failed in LOCK produces no `valid_o`.
- The frame in which LOCK is entered is emitted, because its sync passed.
- Entering HUNT clears `good`, `miss` and `sync_ok`. Entering LOCK clears `miss` and sets `sync_ok`.

## Timing
- Reset values, applied immediately on `RST`=0: all outputs 0, state HUNT, `sr`/`pos`/`good`/`miss`/`sync_ok`/shadow registers 0.
- Reset takes effect mid-frame with no partial output.
- `valid_o` is registered. It is high exactly one cycle, in the cycle after the accepting edge of B203. It is never high on two consecutive cycles.
- `tmcc_info`, `seg_type` and `frame_odd` (output copy) change only together with `valid_o`. They hold between pulses.
- `locked` is registered. It changes in the cycle after the accepting edge of the B16 that causes the transition.
- `ce`=0 freezes all state, including a pending `valid_o`; it stays high until `ce` returns.
- Gaps in `valid_raw` are transparent.

## Test plan
- **Clean lock:** 3 frames with syncs w0, w1, w0; `seg_type`=111; `tmcc_info`=alternating 1010…, LOCK_CNT=2.
  - `locked` rises after frame 2 B16.
  - `valid_o` pulses after frame 2 B203 (`frame_odd`=1) and after frame 3 B203 (`frame_odd`=0, `tmcc_info`=102'h2AAAAAAAAAAAAAAAAAAAAAAAAA).
- **Misaligned start:** 57 random bits containing no sync window, then the clean stream → identical outputs, shifted by 57 bits.
- **Loss of lock:** lock, then corrupt the syncs of 3 consecutive frames, UNLOCK_CNT=3.
  - No `valid_o` for those frames.
  - `locked` falls after the 3rd bad B16.
  - One bad sync followed by a good one → `locked` stays 1 and `miss` resets.
- **Tolerance:** MAX_ERR=1.
  - A single flipped sync bit is accepted.
  - Two flips in LOCK count as a miss.
  - With MAX_ERR=0, a single flip is a miss.
- **Flow control:** the clean stream with random `valid_raw` gaps and random `ce`=0 cycles → same `tmcc_info`/`seg_type` sequence as the gapless run; each `valid_o` is 1 cycle wide.
- **Reset mid-frame:** `RST` low at `pos`≈100 while locked → all outputs 0 asynchronously. After release, the bench re-locks after LOCK_CNT syncs.
